// File: rtl/alu_pkg.sv
// Shared types and default sizing for the sequential ALU responder.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_N     = 4;
    localparam int W         = ALU_WIDTH * ALU_N;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_CMP    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_XOR    = 3'd6,
        OP_PASS_A = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
module alu_shift_add_mul #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [W:0]     sum;

    // Upper half accumulates partial sums; lower half shifts the multiplier out.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        done    = 1'b0;
        sum     = {1'b0, prod_q[2*W-1:W]} + {1'b0, mcand_q & {W{prod_q[0]}}};
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = CW'(W - 1);
            mcand_d = a;
            prod_d  = {{W{1'b0}}, b};
        end else if (busy_q) begin
            prod_d = {sum, prod_q[W-1:1]};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    // Product is presented on the edge that retires the last bit.
    assign product = prod_d;

    always_ff @(posedge clk) begin
        if (arst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked ALU responder: single-cycle ops plus an iterative multiply,
// result registered and flagged with a one-cycle out_valid strobe.
module alu_seq_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int N_ALU = ALU_N
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       enable,
    input  logic [2:0]                 select,
    input  logic [WIDTH*N_ALU-1:0]     a,
    input  logic [WIDTH*N_ALU-1:0]     b,
    output logic                       ready,
    output logic                       out_valid,
    output logic [2*WIDTH*N_ALU-1:0]   out,
    output logic                       carry_out,
    output logic                       a_greater,
    output logic                       a_equal,
    output logic                       a_less
);

    localparam int OW = WIDTH * N_ALU;

    state_e          state_q, state_d;
    logic [OW-1:0]   a_q, a_d, b_q, b_d;
    logic [2*OW-1:0] out_q, out_d;
    logic            carry_q, carry_d;
    logic            gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

    alu_op_e         op;
    logic            accept;
    logic [OW:0]     add_s;
    logic            mul_done;
    logic [2*OW-1:0] mul_prod;

    assign op     = alu_op_e'(select);
    assign accept = enable && (state_q == IDLE);
    assign add_s  = {1'b0, a} + {1'b0, b};

    alu_shift_add_mul #(
        .W(OW)
    ) u_mul (
        .clk     (clk),
        .arst    (arst),
        .start   (accept && (op == OP_MUL)),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Results and flags only move on entry to DONE, so they hold in between.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d = a;
                    b_d = b;
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d = DONE;
                        out_d   = '0;
                        carry_d = 1'b0;
                        gt_d    = a > b;
                        eq_d    = a == b;
                        lt_d    = a < b;
                        unique case (op)
                            OP_ADD: begin
                                out_d[OW:0] = add_s;
                                carry_d     = add_s[OW];
                            end
                            OP_SUB: begin
                                out_d[OW-1:0] = a - b;
                                carry_d       = a < b;
                            end
                            OP_AND:    out_d[OW-1:0] = a & b;
                            OP_OR:     out_d[OW-1:0] = a | b;
                            OP_XOR:    out_d[OW-1:0] = a ^ b;
                            OP_PASS_A: out_d[OW-1:0] = a;
                            default:   out_d = '0;
                        endcase
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                    out_d   = mul_prod;
                    carry_d = 1'b0;
                    gt_d    = a_q > b_q;
                    eq_d    = a_q == b_q;
                    lt_d    = a_q < b_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry_out = carry_q;
    assign a_greater = gt_q;
    assign a_equal   = eq_q;
    assign a_less    = lt_q;

endmodule
